// File: rtl/mem_access_stage.sv
// MEM pipeline stage: branch/jump redirect, data-memory access over a req/ready
// handshake with a bounded wait, and the MEM/WB pipeline registers.
module mem_access_stage #(
  parameter int unsigned N       = 32,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned TW      = 4   // must satisfy TIMEOUT < 2**TW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         regEn,
  input  logic         memRead,
  input  logic         memWrite,
  input  logic         branch,
  input  logic         jump,
  input  logic [N-1:0] NPCbranch,
  input  logic [N-1:0] ALUres,
  input  logic [N-1:0] Bout,
  input  logic         zero,
  input  logic [N-1:0] NPC4in,
  input  logic [N-1:0] ImmIN,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [N-1:0] dmem_addr,
  output logic [N-1:0] dmem_wdata,
  input  logic [N-1:0] dmem_rdata,
  input  logic         dmem_ready,
  output logic         PCsrc,
  output logic [N-1:0] PCtarget,
  output logic         stall,
  output logic         memErr,
  output logic [N-1:0] ReadData,
  output logic [N-1:0] ALUresOut,
  output logic [N-1:0] NPC4out,
  output logic [N-1:0] ImmOut
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          pending;
  logic          start;
  logic          ready_hit;
  logic          abort;
  logic          wb_en;

  // Branch resolution is purely combinational and ignores the access FSM.
  always_comb begin
    PCsrc    = (branch & zero) | jump;
    PCtarget = NPCbranch;
  end

  // Access FSM next state, stall and handshake events.
  always_comb begin
    pending   = regEn & (memRead | memWrite);
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall     = 1'b0;
    start     = 1'b0;
    ready_hit = 1'b0;
    abort     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pending) begin
          stall   = 1'b1;
          start   = 1'b1;
          cnt_d   = '0;
          state_d = StAccess;
        end
      end
      StAccess: begin
        stall = 1'b1;
        if (dmem_ready) begin
          ready_hit = 1'b1;
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == TW'(TIMEOUT - 1)) begin
            abort   = 1'b1;
            state_d = StDone;
          end
        end
      end
      // Stall drops here so the held instruction retires exactly once.
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    wb_en = regEn & ~stall;
  end

  // FSM state and wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered memory request; fields stay stable for the whole access.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else if (start) begin
      dmem_req   <= 1'b1;
      dmem_we    <= memWrite;  // read+write together is treated as a write
      dmem_addr  <= ALUres;
      dmem_wdata <= Bout;
    end else if (ready_hit || abort) begin
      dmem_req <= 1'b0;
    end
  end

  // Sticky timeout flag, only cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      memErr <= 1'b0;
    end else if (abort) begin
      memErr <= 1'b1;
    end
  end

  // Load data: captured on completion of a read, zeroed on abort or non-memory retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      ReadData <= '0;
    end else if (ready_hit && !dmem_we) begin
      ReadData <= dmem_rdata;
    end else if (abort) begin
      ReadData <= '0;
    end else if (wb_en && !(memRead || memWrite)) begin
      ReadData <= '0;
    end
  end

  // Remaining MEM/WB registers advance whenever the pipeline is not stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      ALUresOut <= '0;
      NPC4out   <= '0;
      ImmOut    <= '0;
    end else if (wb_en) begin
      ALUresOut <= ALUres;
      NPC4out   <= NPC4in;
      ImmOut    <= ImmIN;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: stimulus pushes expected memory requests
// and MEM/WB results; independent monitors pop and compare as the DUT presents them.
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic        regEn, memRead, memWrite, branch, jump, zero;
  logic [31:0] NPCbranch, ALUres, Bout, NPC4in, ImmIN;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        PCsrc, stall, memErr;
  logic [31:0] PCtarget, ReadData, ALUresOut, NPC4out, ImmOut;

  mem_access_stage #(.N(32), .TIMEOUT(15), .TW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .regEn      (regEn),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .branch     (branch),
    .jump       (jump),
    .NPCbranch  (NPCbranch),
    .ALUres     (ALUres),
    .Bout       (Bout),
    .zero       (zero),
    .NPC4in     (NPC4in),
    .ImmIN      (ImmIN),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ready (dmem_ready),
    .PCsrc      (PCsrc),
    .PCtarget   (PCtarget),
    .stall      (stall),
    .memErr     (memErr),
    .ReadData   (ReadData),
    .ALUresOut  (ALUresOut),
    .NPC4out    (NPC4out),
    .ImmOut     (ImmOut)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          len;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [31:0] npc4;
    logic [31:0] imm;
  } wb_t;

  req_t req_q[$];
  wb_t  wb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  int   exp_pulses = 0;
  int   delay_cfg = -1;
  logic force_ready = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory responder: raises ready in the request cycle selected by delay_cfg (-1 = never).
  initial begin
    int ridx;
    ridx       = 0;
    dmem_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (dmem_req) begin
        dmem_ready = (delay_cfg >= 0) && (ridx == delay_cfg);
        ridx++;
      end else begin
        dmem_ready = force_ready;
        ridx       = 0;
      end
    end
  end

  // Request monitor: checks fields, stability and pulse length of every dmem_req pulse.
  initial begin
    logic in_req;
    req_t cur;
    int   cur_len;
    in_req  = 1'b0;
    cur_len = 0;
    cur     = '{we: 1'b0, addr: 32'h0, wdata: 32'h0, len: 0};
    forever begin
      @(negedge clk);
      if (dmem_req) begin
        if (!in_req) begin
          in_req  = 1'b1;
          cur_len = 0;
          pulses++;
          if (req_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL req_unexpected: got request addr %h expected none", dmem_addr);
            cur = '{we: dmem_we, addr: dmem_addr, wdata: dmem_wdata, len: -1};
          end else begin
            cur = req_q.pop_front();
          end
        end
        cur_len++;
        check("req_we", {31'b0, dmem_we}, {31'b0, cur.we});
        check("req_addr", dmem_addr, cur.addr);
        if (cur.we) check("req_wdata", dmem_wdata, cur.wdata);
      end else if (in_req) begin
        in_req = 1'b0;
        if (cur.len >= 0) check("req_len", 32'(cur_len), 32'(cur.len));
      end
    end
  end

  // Retire monitor: after every unstalled enabled edge, compare MEM/WB outputs.
  initial begin
    logic ret;
    forever begin
      @(posedge clk);
      ret = regEn && !stall && !rst;
      @(negedge clk);
      if (ret) begin
        if (wb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wb_unexpected: got retire alu %h expected none", ALUresOut);
        end else begin
          wb_t w;
          w = wb_q.pop_front();
          check("wb_readdata", ReadData, w.rdata);
          check("wb_alures", ALUresOut, w.alu);
          check("wb_npc4", NPC4out, w.npc4);
          check("wb_imm", ImmOut, w.imm);
        end
      end
    end
  end

  // Issue one instruction and hold it until it retires.
  task automatic run_instr(input string nm, input logic rd, input logic wr, input logic br,
                           input logic jp, input logic z, input logic [31:0] npcb,
                           input logic [31:0] alu, input logic [31:0] bv,
                           input logic [31:0] npc4, input logic [31:0] imm,
                           input logic [31:0] rdat, input int dly, input int exp_len,
                           input int exp_stall, input logic exp_pcsrc,
                           input logic [31:0] exp_rd);
    int cnt;
    if (rd || wr) begin
      req_q.push_back('{we: wr, addr: alu, wdata: bv, len: exp_len});
      exp_pulses++;
    end
    wb_q.push_back('{rdata: exp_rd, alu: alu, npc4: npc4, imm: imm});
    @(negedge clk);
    delay_cfg = dly;
    memRead = rd; memWrite = wr; branch = br; jump = jp; zero = z;
    NPCbranch = npcb; ALUres = alu; Bout = bv; NPC4in = npc4; ImmIN = imm;
    dmem_rdata = rdat;
    regEn = 1'b1;
    #1;
    check({nm, "_pcsrc"}, {31'b0, PCsrc}, {31'b0, exp_pcsrc});
    check({nm, "_pctarget"}, PCtarget, npcb);
    cnt = 0;
    while (stall && cnt < 40) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    check({nm, "_stall_cycles"}, 32'(cnt), 32'(exp_stall));
    @(posedge clk);
  endtask

  task automatic go_idle();
    @(negedge clk);
    regEn = 1'b0; memRead = 1'b0; memWrite = 1'b0; branch = 1'b0; jump = 1'b0;
  endtask

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    regEn = 1'b0; memRead = 1'b0; memWrite = 1'b0; branch = 1'b0; jump = 1'b0; zero = 1'b0;
    NPCbranch = '0; ALUres = '0; Bout = '0; NPC4in = '0; ImmIN = '0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", {31'b0, dmem_req}, 32'h0);
    check("rst_we", {31'b0, dmem_we}, 32'h0);
    check("rst_addr", dmem_addr, 32'h0);
    check("rst_wdata", dmem_wdata, 32'h0);
    check("rst_readdata", ReadData, 32'h0);
    check("rst_alures", ALUresOut, 32'h0);
    check("rst_npc4", NPC4out, 32'h0);
    check("rst_imm", ImmOut, 32'h0);
    check("rst_memerr", {31'b0, memErr}, 32'h0);
    check("rst_stall", {31'b0, stall}, 32'h0);
    rst = 1'b0;

    //        name        rd wr br jp z  npcb         alu          bout         npc4
    //        imm          rdata        dly len stl pc  exp ReadData
    run_instr("load0",    1, 0, 0, 0, 0, 32'h200,     32'h10,      32'hAAAA,    32'h104,
              32'h4,       32'hDEADBEEF, 0,  1,  2,  0, 32'hDEADBEEF);
    run_instr("store",    0, 1, 0, 0, 0, 32'h200,     32'h20,      32'h12345678, 32'h108,
              32'h8,       32'h55555555, 2,  3,  4,  0, 32'hDEADBEEF);
    run_instr("rdwr",     1, 1, 0, 0, 1, 32'h300,     32'h30,      32'hCAFEF00D, 32'h10C,
              32'hC,       32'h11111111, 1,  2,  3,  0, 32'hDEADBEEF);
    run_instr("br_taken", 0, 0, 1, 0, 1, 32'h100,     32'h7,       32'h0,       32'h110,
              32'h10,      32'h0,        0,  0,  0,  1, 32'h0);
    run_instr("br_not",   0, 0, 1, 0, 0, 32'h100,     32'h8,       32'h0,       32'h114,
              32'h14,      32'h0,        0,  0,  0,  0, 32'h0);
    run_instr("jump",     0, 0, 0, 1, 0, 32'h180,     32'h9,       32'h0,       32'h118,
              32'h18,      32'h0,        0,  0,  0,  1, 32'h0);
    run_instr("b2b_a",    1, 0, 0, 0, 0, 32'h0,       32'h40,      32'h0,       32'h11C,
              32'h1C,      32'h01020304, 0,  1,  2,  0, 32'h01020304);
    run_instr("b2b_b",    1, 0, 0, 0, 0, 32'h0,       32'h44,      32'h0,       32'h120,
              32'h20,      32'h0A0B0C0D, 1,  2,  3,  0, 32'h0A0B0C0D);
    check("memerr_before_timeout", {31'b0, memErr}, 32'h0);
    run_instr("timeout",  1, 0, 0, 0, 0, 32'h0,       32'h50,      32'h0,       32'h124,
              32'h24,      32'hFFFFFFFF, -1, 15, 16, 0, 32'h0);
    check("memerr_set", {31'b0, memErr}, 32'h1);
    run_instr("after_to", 0, 0, 0, 0, 0, 32'h0,       32'h51,      32'h0,       32'h128,
              32'h28,      32'h0,        0,  0,  0,  0, 32'h0);
    run_instr("load_pre", 1, 0, 0, 0, 0, 32'h0,       32'h58,      32'h0,       32'h12C,
              32'h2C,      32'h00000077, 0,  1,  2,  0, 32'h00000077);
    check("memerr_sticky", {31'b0, memErr}, 32'h1);

    // Reset during the second ACCESS cycle of a load that never completes.
    req_q.push_back('{we: 1'b0, addr: 32'h60, wdata: 32'h0, len: 2});
    exp_pulses++;
    @(negedge clk);
    delay_cfg = -1;
    memRead = 1'b1; memWrite = 1'b0; branch = 1'b0; jump = 1'b0;
    ALUres = 32'h60; NPC4in = 32'h130; ImmIN = 32'h30; dmem_rdata = 32'h99999999;
    regEn = 1'b1;
    begin
      int w;
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!dmem_req && w < 5);
      check("rstmid_req_seen", {31'b0, dmem_req}, 32'h1);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; regEn = 1'b0; memRead = 1'b0;
    #1;
    check("rstmid_req", {31'b0, dmem_req}, 32'h0);
    check("rstmid_readdata", ReadData, 32'h0);
    check("rstmid_alures", ALUresOut, 32'h0);
    check("rstmid_npc4", NPC4out, 32'h0);
    check("rstmid_imm", ImmOut, 32'h0);
    check("rstmid_memerr", {31'b0, memErr}, 32'h0);
    force_ready = 1'b1;
    @(negedge clk);
    #1;
    force_ready = 1'b0;
    @(negedge clk);
    #1;
    check("late_ready_readdata", ReadData, 32'h0);
    check("late_ready_req", {31'b0, dmem_req}, 32'h0);
    check("late_ready_stall", {31'b0, stall}, 32'h0);

    run_instr("load_post", 1, 0, 0, 0, 0, 32'h0,      32'h70,      32'h0,       32'h134,
              32'h34,      32'h13572468, 0,  1,  2,  0, 32'h13572468);
    go_idle();
    repeat (4) @(negedge clk);
    check("req_queue_drained", 32'(req_q.size()), 32'h0);
    check("wb_queue_drained", 32'(wb_q.size()), 32'h0);
    check("req_pulse_count", 32'(pulses), 32'(exp_pulses));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
